// File: rtl/alu_op_sequencer.sv
// Sequencer front end for the 4-bit shift/arithmetic ALU: operation FIFO, registered ALU operands, held result.
// Optional accumulator chaining is built when ALU_SEQ_ACC_EN is defined.
module alu_op_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_op,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    input  logic       in_cin,
    input  logic       in_use_acc,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_s,
    output logic       alu_cin,
    input  logic [3:0] alu_result,
    input  logic       alu_cout,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_result,
    output logic       out_cout,
    output logic       out_zero,
    output logic [3:0] acc,
    output logic       busy,
    output logic [1:0] state_dbg
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, HOLD = 2'd2} state_t;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
`ifdef ALU_SEQ_ACC_EN
        logic       use_acc;
`endif
    } entry_t;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid never waits for ready, and the producer holds its data stable until the transfer.
    state_t         state;
    entry_t         mem [DEPTH];
    entry_t         wr_entry;
    entry_t         head;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           empty;
    logic           full;
    logic           push;
    logic           pop;
    logic [3:0]     a_sel;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign push  = in_valid && !full;
    assign pop   = !empty && ((state == IDLE) || ((state == HOLD) && out_ready));
    assign head  = mem[rd_ptr[AW-1:0]];

    assign in_ready  = !full;
    assign busy      = (state != IDLE) || !empty;
    assign state_dbg = state;

    always_comb begin
        wr_entry     = '0;
        wr_entry.op  = in_op;
        wr_entry.a   = in_a;
        wr_entry.b   = in_b;
        wr_entry.cin = in_cin;
`ifdef ALU_SEQ_ACC_EN
        wr_entry.use_acc = in_use_acc;
`endif
    end

`ifdef ALU_SEQ_ACC_EN
    logic [3:0] acc_q;
    assign acc   = acc_q;
    // acc was written in the EXEC of the previous operation, so it is current at every pop.
    assign a_sel = head.use_acc ? acc_q : head.a;
`else
    logic unused_use_acc;
    assign unused_use_acc = in_use_acc;
    assign acc   = 4'd0;
    assign a_sel = head.a;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            alu_s      <= 4'd0;
            alu_cin    <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= 4'd0;
            out_cout   <= 1'b0;
            out_zero   <= 1'b1;
`ifdef ALU_SEQ_ACC_EN
            acc_q      <= 4'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        alu_a   <= a_sel;
                        alu_b   <= head.b;
                        alu_s   <= head.op;
                        alu_cin <= head.cin;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    out_result <= alu_result;
                    out_cout   <= alu_cout;
                    out_zero   <= (alu_result == 4'd0);
`ifdef ALU_SEQ_ACC_EN
                    acc_q      <= alu_result;
`endif
                    out_valid  <= 1'b1;
                    state      <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (pop) begin
                            alu_a   <= a_sel;
                            alu_b   <= head.b;
                            alu_s   <= head.op;
                            alu_cin <= head.cin;
                            state   <= EXEC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
